// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the program loader: the data-path widths and the
// loader state encoding. The loader and its byte-pairing sub-module import
// this package.
// -----------------------------------------------------------------------------
package loader_pkg;

    localparam int unsigned ADDR_W = 8;   // RAM word address width
    localparam int unsigned WORD_W = 16;  // RAM word width
    localparam int unsigned CNT_W  = 9;   // word count, 0..256
    localparam int unsigned BYTE_W = 8;   // byte-stream width

    // IDLE  : CPU held in reset, waiting for the first load request
    // HI/LO : collecting the high / low byte of the current word
    // WRITE : one-cycle RAM write of the assembled word
    // RUN   : CPU released, loader waiting for a reload request
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HI    = 3'd1,
        LO    = 3'd2,
        WRITE = 3'd3,
        RUN   = 3'd4
    } state_t;

endpackage

// File: rtl/word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Pairs two bytes from the load stream into one RAM word. The high byte is
// parked internally; the output word only changes when the low byte arrives,
// so it stays stable between RAM writes.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous active-low reset; clears any partial word
//   load_hi  in   capture in_byte as the high byte
//   load_lo  in   capture in_byte as the low byte and publish the word
//   in_byte  in   byte from the stream
//   word     out  last complete word {high, low}
// -----------------------------------------------------------------------------
module word_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_hi,
    input  logic              load_lo,
    input  logic [BYTE_W-1:0] in_byte,
    output logic [WORD_W-1:0] word
);

    logic [BYTE_W-1:0] hi_byte;

    // NOTE: state registers use non-blocking assignments so every register in
    // the block sees the pre-edge values of the others, matching the hardware.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_byte <= '0;
            word    <= '0;
        end else begin
            if (load_hi) begin
                hi_byte <= in_byte;
            end
            if (load_lo) begin
                word <= {hi_byte, in_byte};
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Loads a program image from a byte stream into the CPU's instruction RAM,
// holding the CPU in reset while loading and releasing it afterwards with the
// load base as its start address. Each RAM word arrives high byte first.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   ld_start    in   one-cycle load request
//   ld_base     in   first RAM word address (sampled with ld_start)
//   ld_count    in   number of words, 0..256 (sampled with ld_start)
//   in_valid    in   byte-stream valid
//   in_byte     in   byte-stream data
//   in_ready    out  byte-stream ready (HI and LO only)
//   ram_w_en    out  RAM write strobe, one cycle per word
//   ram_w_addr  out  RAM write address, held between writes
//   ram_w_data  out  RAM write data, held between writes
//   cpu_rst_n   out  active-low CPU reset, high only in RUN
//   start_pc    out  CPU start address (base of the last accepted load)
//   busy        out  load in progress (HI, LO, WRITE)
//   err         out  one-cycle pulse on a load request with ld_count == 0
// -----------------------------------------------------------------------------
module prog_loader
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [CNT_W-1:0]  ld_count,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_byte,
    output logic              in_ready,
    output logic              ram_w_en,
    output logic [ADDR_W-1:0] ram_w_addr,
    output logic [WORD_W-1:0] ram_w_data,
    output logic              cpu_rst_n,
    output logic [ADDR_W-1:0] start_pc,
    output logic              busy,
    output logic              err
);

    state_t            state;
    logic [ADDR_W-1:0] addr;       // address of the word being collected
    logic [CNT_W-1:0]  remaining;  // words still to write, including current
    logic              xfer;
    logic              load_hi;
    logic              load_lo;

    // in_ready is only ever high in HI and LO, so a transfer implies one of
    // those two states.
    assign xfer    = in_valid & in_ready;
    assign load_hi = xfer & (state == HI);
    assign load_lo = xfer & (state == LO);

    // The assembler's word only changes when the low byte lands, which is
    // the same edge that raises ram_w_en, so it can drive ram_w_data directly
    // and still hold between writes.
    word_assembler u_word_assembler (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_hi (load_hi),
        .load_lo (load_lo),
        .in_byte (in_byte),
        .word    (ram_w_data)
    );

    // Control FSM. All outputs are registered and set on the edge that enters
    // the state they belong to, so they are valid for the whole state cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            remaining  <= '0;
            in_ready   <= 1'b0;
            ram_w_en   <= 1'b0;
            ram_w_addr <= '0;
            cpu_rst_n  <= 1'b0;
            start_pc   <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            // Single-cycle strobes default low and are raised only where needed.
            err      <= 1'b0;
            ram_w_en <= 1'b0;

            case (state)
                IDLE, RUN: begin
                    if (ld_start) begin
                        if (ld_count != '0) begin
                            addr      <= ld_base;
                            start_pc  <= ld_base;
                            remaining <= ld_count;
                            cpu_rst_n <= 1'b0;
                            busy      <= 1'b1;
                            in_ready  <= 1'b1;
                            state     <= HI;
                        end else begin
                            // Rejected request: current state and outputs stay.
                            err <= 1'b1;
                        end
                    end
                end

                // ld_start is deliberately not examined in HI, LO or WRITE.
                HI: begin
                    if (xfer) begin
                        state <= LO;
                    end
                end

                LO: begin
                    if (xfer) begin
                        in_ready   <= 1'b0;
                        ram_w_en   <= 1'b1;
                        ram_w_addr <= addr;
                        state      <= WRITE;
                    end
                end

                WRITE: begin
                    // Address wraps naturally at ADDR_W bits (0xFF -> 0x00).
                    addr      <= addr + ADDR_W'(1);
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        busy      <= 1'b0;
                        cpu_rst_n <= 1'b1;
                        state     <= RUN;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= HI;
                    end
                end

                default: begin
                    busy      <= 1'b0;
                    in_ready  <= 1'b0;
                    cpu_rst_n <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
// Directed self-checking bench for prog_loader. Inputs are driven on the
// falling edge and outputs are compared on the falling edge; a posedge
// monitor records every RAM write for later comparison.
// -----------------------------------------------------------------------------
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_start = 1'b0;
    logic [7:0]  ld_base = '0;
    logic [8:0]  ld_count = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = '0;
    logic        in_ready;
    logic        ram_w_en;
    logic [7:0]  ram_w_addr;
    logic [15:0] ram_w_data;
    logic        cpu_rst_n;
    logic [7:0]  start_pc;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  wr_addr_q[$];
    logic [15:0] wr_data_q[$];

    prog_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_start   (ld_start),
        .ld_base    (ld_base),
        .ld_count   (ld_count),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .ram_w_en   (ram_w_en),
        .ram_w_addr (ram_w_addr),
        .ram_w_data (ram_w_data),
        .cpu_rst_n  (cpu_rst_n),
        .start_pc   (start_pc),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Values seen here are those of the cycle that just ended.
    always @(posedge clk) begin
        if (ram_w_en === 1'b1) begin
            wr_addr_q.push_back(ram_w_addr);
            wr_data_q.push_back(ram_w_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- helpers
    task automatic start_load(input logic [7:0] base, input logic [8:0] cnt);
        ld_start = 1'b1;
        ld_base  = base;
        ld_count = cnt;
        @(negedge clk);
        ld_start = 1'b0;
    endtask

    // Offers one byte and returns on the falling edge after it was accepted.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        in_valid = 1'b1;
        in_byte  = b;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_rst_n: got %b required 0", cpu_rst_n); end
        n_checks++; if (ram_w_en !== 1'b0) begin n_fail++; $display("FAIL reset_ram_w_en: got %b required 0", ram_w_en); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", err); end
        n_checks++; if (start_pc !== 8'h00) begin n_fail++; $display("FAIL reset_start_pc: got %h required 00", start_pc); end
        n_checks++; if (ram_w_data !== 16'h0000) begin n_fail++; $display("FAIL reset_ram_w_data: got %h required 0000", ram_w_data); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b cpu_rst_n=%b required 0/0", busy, cpu_rst_n); end
    endtask

    task automatic test_basic_load();
        int q0 = wr_addr_q.size();
        start_load(8'h10, 9'd2);
        n_checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_hi_entry: busy=%b in_ready=%b required 1/1", busy, in_ready); end
        n_checks++; if (start_pc !== 8'h10) begin n_fail++; $display("FAIL basic_start_pc_latch: got %h required 10", start_pc); end
        n_checks++; if (cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL basic_cpu_rst_load: got %b required 0", cpu_rst_n); end
        send_byte(8'hA0);
        send_byte(8'h01);
        // Write cycle directly after the low byte edge.
        n_checks++; if (ram_w_en !== 1'b1) begin n_fail++; $display("FAIL basic_w1_en: got %b required 1", ram_w_en); end
        n_checks++; if (ram_w_addr !== 8'h10) begin n_fail++; $display("FAIL basic_w1_addr: got %h required 10", ram_w_addr); end
        n_checks++; if (ram_w_data !== 16'hA001) begin n_fail++; $display("FAIL basic_w1_data: got %h required a001", ram_w_data); end
        n_checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_write_flags: in_ready=%b busy=%b required 0/1", in_ready, busy); end
        @(negedge clk);
        n_checks++; if (ram_w_en !== 1'b0) begin n_fail++; $display("FAIL basic_w1_single: ram_w_en=%b required 0", ram_w_en); end
        n_checks++; if (ram_w_data !== 16'hA001 || ram_w_addr !== 8'h10) begin n_fail++; $display("FAIL basic_hold: addr=%h data=%h required 10/a001", ram_w_addr, ram_w_data); end
        n_checks++; if (in_ready !== 1'b1 || cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL basic_next_hi: in_ready=%b cpu_rst_n=%b required 1/0", in_ready, cpu_rst_n); end
        send_byte(8'hB0);
        send_byte(8'h02);
        n_checks++; if (ram_w_en !== 1'b1 || ram_w_addr !== 8'h11 || ram_w_data !== 16'hB002) begin n_fail++; $display("FAIL basic_w2: en=%b addr=%h data=%h required 1/11/b002", ram_w_en, ram_w_addr, ram_w_data); end
        n_checks++; if (cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL basic_cpu_rst_during_w2: got %b required 0", cpu_rst_n); end
        @(negedge clk);
        n_checks++; if (cpu_rst_n !== 1'b1) begin n_fail++; $display("FAIL basic_cpu_release: got %b required 1", cpu_rst_n); end
        n_checks++; if (busy !== 1'b0 || ram_w_en !== 1'b0) begin n_fail++; $display("FAIL basic_run_flags: busy=%b ram_w_en=%b required 0/0", busy, ram_w_en); end
        n_checks++; if (start_pc !== 8'h10) begin n_fail++; $display("FAIL basic_start_pc_run: got %h required 10", start_pc); end
        n_checks++; if (wr_addr_q.size() != q0 + 2) begin n_fail++; $display("FAIL basic_write_count: got %0d required %0d", wr_addr_q.size() - q0, 2); end
    endtask

    task automatic test_err_in_run();
        start_load(8'h77, 9'd0);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_run_pulse: got %b required 1", err); end
        n_checks++; if (cpu_rst_n !== 1'b1 || busy !== 1'b0 || start_pc !== 8'h10) begin n_fail++; $display("FAIL err_run_state: cpu_rst_n=%b busy=%b start_pc=%h required 1/0/10", cpu_rst_n, busy, start_pc); end
        @(negedge clk);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_run_single: got %b required 0", err); end
        n_checks++; if (cpu_rst_n !== 1'b1) begin n_fail++; $display("FAIL err_run_cpu_rst: got %b required 1", cpu_rst_n); end
    endtask

    task automatic test_wrap_and_ignore();
        int q0 = wr_addr_q.size();
        start_load(8'hFF, 9'd2);
        // Requests while busy must neither pulse err nor alter latched values.
        start_load(8'h55, 9'd3);
        n_checks++; if (err !== 1'b0 || start_pc !== 8'hFF || busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy_start: err=%b start_pc=%h busy=%b required 0/ff/1", err, start_pc, busy); end
        start_load(8'h66, 9'd0);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_zero: err=%b required 0", err); end
        send_byte(8'h12);
        send_byte(8'h34);
        n_checks++; if (ram_w_addr !== 8'hFF || ram_w_data !== 16'h1234) begin n_fail++; $display("FAIL wrap_w1: addr=%h data=%h required ff/1234", ram_w_addr, ram_w_data); end
        send_byte(8'h56);
        send_byte(8'h78);
        n_checks++; if (ram_w_addr !== 8'h00 || ram_w_data !== 16'h5678) begin n_fail++; $display("FAIL wrap_w2: addr=%h data=%h required 00/5678", ram_w_addr, ram_w_data); end
        @(negedge clk);
        n_checks++; if (cpu_rst_n !== 1'b1 || start_pc !== 8'hFF) begin n_fail++; $display("FAIL wrap_run: cpu_rst_n=%b start_pc=%h required 1/ff", cpu_rst_n, start_pc); end
        n_checks++; if (wr_addr_q.size() != q0 + 2) begin n_fail++; $display("FAIL wrap_write_count: got %0d required 2", wr_addr_q.size() - q0); end
    endtask

    task automatic test_throttled_stream();
        logic [7:0] bytes [2];
        int idx = 0;
        int q0 = wr_addr_q.size();
        bytes[0] = 8'hC3;
        bytes[1] = 8'h5A;
        start_load(8'h30, 9'd1);
        for (int cyc = 0; cyc < 40 && idx < 2; cyc++) begin
            in_valid = (cyc % 2 == 0);
            in_byte  = bytes[idx];
            if (in_valid && in_ready === 1'b1) idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++; if (idx != 2) begin n_fail++; $display("FAIL throttle_timeout: accepted %0d bytes required 2", idx); end
        n_checks++; if (ram_w_en !== 1'b1 || ram_w_addr !== 8'h30 || ram_w_data !== 16'hC35A) begin n_fail++; $display("FAIL throttle_write: en=%b addr=%h data=%h required 1/30/c35a", ram_w_en, ram_w_addr, ram_w_data); end
        repeat (3) @(negedge clk);
        n_checks++; if (wr_addr_q.size() != q0 + 1) begin n_fail++; $display("FAIL throttle_write_count: got %0d required 1", wr_addr_q.size() - q0); end
        n_checks++; if (cpu_rst_n !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL throttle_run: cpu_rst_n=%b busy=%b required 1/0", cpu_rst_n, busy); end
    endtask

    task automatic test_reset_abort();
        int q0;
        start_load(8'h40, 9'd1);
        send_byte(8'h11);
        // Now in LO; reset wins over a simultaneous transfer and ld_start.
        q0 = wr_addr_q.size();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_byte  = 8'h22;
        ld_start = 1'b1;
        ld_base  = 8'h99;
        ld_count = 9'd1;
        @(negedge clk);
        in_valid = 1'b0;
        ld_start = 1'b0;
        n_checks++; if (cpu_rst_n !== 1'b0 || ram_w_en !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_outputs: cpu_rst_n=%b ram_w_en=%b in_ready=%b required 0/0/0", cpu_rst_n, ram_w_en, in_ready); end
        n_checks++; if (busy !== 1'b0 || err !== 1'b0 || start_pc !== 8'h00) begin n_fail++; $display("FAIL abort_status: busy=%b err=%b start_pc=%h required 0/0/00", busy, err, start_pc); end
        n_checks++; if (ram_w_data !== 16'h0000) begin n_fail++; $display("FAIL abort_data: got %h required 0000", ram_w_data); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (wr_addr_q.size() != q0) begin n_fail++; $display("FAIL abort_no_write: got %0d writes required 0", wr_addr_q.size() - q0); end
        n_checks++; if (busy !== 1'b0 || cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL abort_idle: busy=%b cpu_rst_n=%b required 0/0", busy, cpu_rst_n); end
        // Zero-count request in IDLE.
        start_load(8'h00, 9'd0);
        n_checks++; if (err !== 1'b1 || cpu_rst_n !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL err_idle: err=%b cpu_rst_n=%b busy=%b required 1/0/0", err, cpu_rst_n, busy); end
        @(negedge clk);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_idle_single: got %b required 0", err); end
        // Fresh load after the abort.
        start_load(8'h80, 9'd1);
        send_byte(8'h12);
        send_byte(8'h34);
        n_checks++; if (ram_w_en !== 1'b1 || ram_w_addr !== 8'h80 || ram_w_data !== 16'h1234) begin n_fail++; $display("FAIL abort_fresh_write: en=%b addr=%h data=%h required 1/80/1234", ram_w_en, ram_w_addr, ram_w_data); end
        @(negedge clk);
        n_checks++; if (cpu_rst_n !== 1'b1 || start_pc !== 8'h80) begin n_fail++; $display("FAIL abort_fresh_run: cpu_rst_n=%b start_pc=%h required 1/80", cpu_rst_n, start_pc); end
    endtask

    task automatic test_restart_from_run();
        start_load(8'h20, 9'd1);
        n_checks++; if (cpu_rst_n !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL restart_entry: cpu_rst_n=%b busy=%b required 0/1", cpu_rst_n, busy); end
        n_checks++; if (start_pc !== 8'h20) begin n_fail++; $display("FAIL restart_start_pc: got %h required 20", start_pc); end
        send_byte(8'hDE);
        send_byte(8'hAD);
        n_checks++; if (ram_w_en !== 1'b1 || ram_w_addr !== 8'h20 || ram_w_data !== 16'hDEAD) begin n_fail++; $display("FAIL restart_write: en=%b addr=%h data=%h required 1/20/dead", ram_w_en, ram_w_addr, ram_w_data); end
        @(negedge clk);
        n_checks++; if (cpu_rst_n !== 1'b1 || start_pc !== 8'h20) begin n_fail++; $display("FAIL restart_run: cpu_rst_n=%b start_pc=%h required 1/20", cpu_rst_n, start_pc); end
    endtask

    task automatic test_full_256();
        int q0 = wr_addr_q.size();
        logic [7:0] b;
        logic [7:0]  exp_addr;
        logic [15:0] exp_data;
        start_load(8'h80, 9'd256);
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            send_byte(b);
            send_byte(~b);
        end
        @(negedge clk);
        n_checks++; if (cpu_rst_n !== 1'b1 || busy !== 1'b0 || start_pc !== 8'h80) begin n_fail++; $display("FAIL full_run: cpu_rst_n=%b busy=%b start_pc=%h required 1/0/80", cpu_rst_n, busy, start_pc); end
        n_checks++; if (wr_addr_q.size() != q0 + 256) begin n_fail++; $display("FAIL full_write_count: got %0d required 256", wr_addr_q.size() - q0); end
        else begin
            for (int i = 0; i < 256; i++) begin
                b        = i[7:0];
                exp_addr = 8'h80 + b;
                exp_data = {b, ~b};
                n_checks++;
                if (wr_addr_q[q0 + i] !== exp_addr || wr_data_q[q0 + i] !== exp_data) begin
                    n_fail++;
                    $display("FAIL full_word_%0d: addr=%h data=%h required %h/%h", i, wr_addr_q[q0 + i], wr_data_q[q0 + i], exp_addr, exp_data);
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_load();
        test_err_in_run();
        test_wrap_and_ignore();
        test_throttled_stream();
        test_reset_abort();
        test_restart_from_run();
        test_full_256();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port ld_start  input  1  one-cycle request to begin a load.
REQ-004 SHALL have port ld_base  input  8  first RAM word address, sampled with ld_start.
REQ-005 SHALL have port ld_count  input  9  number of 16-bit words to load (0..256), sampled with ld_start.
REQ-006 SHALL have port in_valid  input  1  byte-stream valid.
REQ-007 SHALL have port in_byte  input  8  byte-stream data.
REQ-008 SHALL have port in_ready  output  1  byte-stream ready; a byte transfers when in_valid & in_ready on a rising edge.
REQ-009 SHALL have port ram_w_en  output  1  RAM write strobe.
REQ-010 SHALL have port ram_w_addr  output  8  RAM write address.
REQ-011 SHALL have port ram_w_data  output  16  RAM write data.
REQ-012 SHALL have port cpu_rst_n  output  1  active-low CPU reset, driven from a register.
REQ-013 SHALL have port start_pc  output  8  CPU start address; holds the latched ld_base.
REQ-014 SHALL have port busy  output  1  high while a load is in progress.
REQ-015 SHALL have port err  output  1  one-cycle pulse on a rejected ld_start.

Function
REQ-016 SHALL implement states IDLE, HI, LO, WRITE, RUN.
REQ-017 IDLE: cpu_rst_n=0; ld_start with ld_count!=0 SHALL latch ld_base/ld_count and go to HI next cycle.
REQ-018 IDLE or RUN: ld_start with ld_count==0 SHALL pulse err for one cycle; state is unchanged.
REQ-019 HI: in_ready=1; an accepted byte SHALL become data[15:8]; next state LO.
REQ-020 LO: in_ready=1; an accepted byte SHALL become data[7:0]; next state WRITE.
REQ-021 HI/LO without a transfer SHALL hold state; in_ready SHALL be 0 in every other state.
REQ-022 WRITE: ram_w_en=1 for exactly one cycle, with ram_w_addr = current address and ram_w_data = assembled word.
REQ-023 WRITE latency: the write SHALL occur the cycle after the low byte is accepted.
REQ-024 After each WRITE, the address SHALL increment modulo 256 (255 wraps to 0) and the remaining count SHALL decrement; go to HI if remaining != 0, else RUN.
REQ-025 busy SHALL be 1 in HI, LO and WRITE, and 0 otherwise.
REQ-026 cpu_rst_n SHALL be 0 in IDLE, HI, LO and WRITE, and 1 from the first RUN cycle; this gives the CPU at least one full low-reset cycle after the final write.
REQ-027 RUN: ld_start with ld_count!=0 SHALL drive cpu_rst_n=0 and restart the load (go to HI) with the new base/count.
REQ-028 ld_start while busy SHALL be ignored: no err and no change to the latched values.
REQ-029 ld_count=256 SHALL load all 256 words, fully wrapping the address space.
REQ-030 start_pc SHALL update only when a load is accepted.
REQ-031 ram_w_addr and ram_w_data SHALL hold their last values when ram_w_en=0.

Reset
REQ-032 rst_n=0 SHALL force, at the next edge: state IDLE, cpu_rst_n=0, ram_w_en=0, in_ready=0, busy=0, err=0, start_pc=0, address=0, remaining=0, data=0.
REQ-033 Reset during HI, LO or WRITE SHALL abort the load with no further RAM write; any partial word SHALL be discarded.
REQ-034 rst_n SHALL take priority over ld_start and any stream transfer in the same cycle.

Structure
REQ-035 State enum and the width constants (ADDR_W=8, WORD_W=16, CNT_W=9) SHALL reside in the shared package loader_pkg.
REQ-036 Byte pairing SHALL be a sub-module, word_assembler: load_hi, load_lo and byte in; 16-bit word out.
REQ-037 prog_loader SHALL connect to the existing ram write port and to the CPU's rst_n/start_pc, with no changes to those blocks.

Verification
REQ-038 Load base=0x10, count=2, bytes A0 01 B0 02 -> writes 0xA001@0x10 then 0xB002@0x11; cpu_rst_n rises one cycle after the second write; start_pc=0x10.
REQ-039 in_valid toggling every other cycle during a count=1 load -> exactly one write, data correct, no byte lost or duplicated.
REQ-040 Base=0xFF, count=2 -> writes at 0xFF then 0x00.
REQ-041 ld_start with count=0 -> single err pulse, state and cpu_rst_n unchanged; a second ld_start while busy is ignored.
REQ-042 rst_n=0 right after the high byte is accepted -> no RAM write and all outputs at reset values; a fresh load then writes correctly.
REQ-043 In RUN, ld_start with base=0x20, count=1 -> cpu_rst_n falls next cycle, write lands @0x20, then RUN resumes with start_pc=0x20.
